fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// Instruction-supply side of the control unit: fetches a word from instruction memory, holds it in an
// instruction register, presents opcode/funct and register fields to `control`, and waits for its
// pc_write strobe. It then resolves the next PC from the jump/jal/jr/branch flags and ALU compare results.
// Sits between the instruction memory and control/datapath in `process`.
// PARAMETERS
// RESET_PC       32'h0000_0000  PC loaded on reset; must be word-aligned
// FETCH_TIMEOUT  16             max cycles waiting for imem_valid before fault
// PORTS
// CLOCK_50        in   1   system clock, rising edge
// Reset           in   1   asynchronous, active-low reset (0 = in reset)
// Run             in   1   1 = sequence instructions; 0 = stop at next instruction boundary
// imem_addr       out  32  fetch address (= pc_out while fetching)
// imem_req        out  1   fetch request, high in FETCH
// imem_data       in   32  instruction word
// imem_valid      in   1   imem_data valid this cycle (handshake with imem_req)
// opcode,funct    out  6   IR[31:26], IR[5:0]
// rs_addr,rt_addr,rd_addr,shamt  out 5  IR[25:21], IR[20:16], IR[15:11], IR[10:6]
// imm             out  16  IR[15:0]
// instr_valid     out  1   IR fields valid for control (high in DECODE)
// pc_write        in   1   control: instruction complete; update PC this edge
// jump,jal,jr     in   1   control jump flags
// brancheq,branchnotequal,branchgreaterthan,branchlessthan,branchlessthanorequal,
//   branchgreaterthanorequal  in 1  control branch flags
// zero            in   1   ALU: rs==rt
// lt              in   1   ALU: signed rs<rt
// rs_data         in   32  register rs value (jr target)
// pc_out          out  32  current PC
// pcp4            out  32  pc_out+4 (also jal link value for r31)
// instr_count     out  32  retired-instruction counter
// fault           out  1   sticky: fetch timeout or misaligned jr target
// BEHAVIOUR
// Reset (Reset==0, async): state=IDLE, pc_out=RESET_PC, IR=0, instr_count=0, fault=0,
//   imem_req=0, instr_valid=0. All field outputs are 0.
// FSM: IDLE -> FETCH when Run=1 and fault=0.
//   FETCH: imem_req=1, imem_addr=pc_out. On imem_valid: IR<=imem_data, goto DECODE.
//     Timer counts FETCH cycles; at FETCH_TIMEOUT without imem_valid: fault<=1, goto IDLE.
//   DECODE: instr_valid=1, fields driven from IR (stable). Wait for pc_write; 1 clock min.
//     On pc_write: pc_out<=next_pc, instr_count<=instr_count+1 (wraps at 2^32).
//     Then goto FETCH if Run=1, else IDLE.
// Latency: imem_valid in FETCH -> instr_valid next cycle; pc_write -> new imem_addr next cycle.
// pc_write outside DECODE is ignored. Run=0 mid-instruction completes the current instruction first.
// taken = brancheq&zero | branchnotequal&~zero | branchgreaterthan&~lt&~zero | branchlessthan&lt
//   | branchlessthanorequal&(lt|zero) | branchgreaterthanorequal&~lt.
// next_pc priority: jr -> {rs_data[31:2],2'b00}; else jump|jal -> {pcp4[31:28],IR[25:0],2'b00};
//   else taken -> pcp4 + {{14{imm[15]}},imm,2'b00} (mod 2^32); else pcp4.
// jr with rs_data[1:0]!=0: PC still loads the aligned value, fault<=1, then IDLE.
// fault is cleared only by reset. While fault=1, FSM stays in IDLE.
// pcp4 is combinational from pc_out; it wraps 32'hFFFF_FFFC -> 0.
// TESTING
// Reset low, Run=1, imem_valid=1 with 0x012A4020 (add) -> opcode=0, funct=0x20, rs=9, rt=10, rd=8.
//   Then pc_write -> pc_out=4, instr_count=1.
// beq (0x1109_0003) at pc 0x10, zero=1, pc_write -> pc_out=0x20; same with zero=0 -> pc_out=0x14.
// jal 0x0C00_0040 at pc 0x1000_0008 -> pc_out=0x1000_0100, pcp4=0x1000_000C at decision.
// jr with rs_data=0x0000_0203 -> pc_out=0x200, fault=1, FSM in IDLE, imem_req=0 despite Run=1.
// imem_valid held low 16 cycles -> fault=1, IDLE. Run=0 during DECODE -> PC updates, then IDLE.
// Reset pulled low mid-DECODE -> immediate pc_out=RESET_PC, instr_valid=0, instr_count=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode sequencer: fetches into an instruction register, exposes its fields to
// control, and resolves the next PC from jump/branch flags when control strobes pc_write.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic        Run,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        instr_valid,
  input  logic        pc_write,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        brancheq,
  input  logic        branchnotequal,
  input  logic        branchgreaterthan,
  input  logic        branchlessthan,
  input  logic        branchlessthanorequal,
  input  logic        branchgreaterthanorequal,
  input  logic        zero,
  input  logic        lt,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_out,
  output logic [31:0] pcp4,
  output logic [31:0] instr_count,
  output logic        fault
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(FETCH_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          taken;
  logic [31:0]   pc_plus4;
  logic [31:0]   next_pc;
  logic          jr_misaligned;

  assign pc_plus4      = pc_q + 32'd4;
  assign jr_misaligned = jr && (rs_data[1:0] != 2'b00);

  always_comb begin
    taken = (brancheq                 &&  zero)
          | (branchnotequal           && !zero)
          | (branchgreaterthan        && !lt && !zero)
          | (branchlessthan           &&  lt)
          | (branchlessthanorequal    && (lt || zero))
          | (branchgreaterthanorequal && !lt);

    next_pc = pc_plus4;
    if (jr)
      next_pc = {rs_data[31:2], 2'b00};
    else if (jump || jal)
      next_pc = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    else if (taken)
      next_pc = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (Run && !fault_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          timer_d = '0;
          state_d = S_DECODE;
        end else if (timer_q == TIMER_LAST) begin
          fault_d = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DECODE: begin
        if (pc_write) begin
          pc_d  = next_pc;
          cnt_d = cnt_q + 32'd1;
          // A misaligned jr still commits the aligned PC, then parks the sequencer.
          if (jr_misaligned) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = Run ? S_FETCH : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      timer_q <= timer_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_DECODE);
  assign opcode      = ir_q[31:26];
  assign rs_addr     = ir_q[25:21];
  assign rt_addr     = ir_q[20:16];
  assign rd_addr     = ir_q[15:11];
  assign shamt       = ir_q[10:6];
  assign funct       = ir_q[5:0];
  assign imm         = ir_q[15:0];
  assign pc_out      = pc_q;
  assign pcp4        = pc_plus4;
  assign instr_count = cnt_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: walks a hand-computed instruction sequence through the PC logic.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run;
  logic [31:0] imem_addr, imem_data;
  logic        imem_req, imem_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_addr, rt_addr, rd_addr, shamt;
  logic [15:0] imm;
  logic        instr_valid, pc_write;
  logic        jump, jal, jr, beq, bne, bgt, blt, ble, bge, zero, lt;
  logic [31:0] rs_data, pc_out, pcp4, instr_count;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
    .CLOCK_50(clk), .Reset(rst_n), .Run(run),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_data(imem_data), .imem_valid(imem_valid),
    .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .shamt(shamt), .imm(imm), .instr_valid(instr_valid), .pc_write(pc_write),
    .jump(jump), .jal(jal), .jr(jr),
    .brancheq(beq), .branchnotequal(bne), .branchgreaterthan(bgt), .branchlessthan(blt),
    .branchlessthanorequal(ble), .branchgreaterthanorequal(bge),
    .zero(zero), .lt(lt), .rs_data(rs_data),
    .pc_out(pc_out), .pcp4(pcp4), .instr_count(instr_count), .fault(fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    {jump, jal, jr, beq, bne, bgt, blt, ble, bge, zero, lt} = '0;
    rs_data = '0;
  endtask

  // Called while in FETCH: present one word, land in DECODE.
  task automatic fetch(input string tag, input logic [31:0] w);
    imem_valid = 1'b1;
    imem_data  = w;
    tick();
    imem_valid = 1'b0;
    chk({tag, ".instr_valid"}, {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire();
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    clear_flags();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; imem_valid = 1'b1; imem_data = 32'h012A_4020; pc_write = 1'b0;
    clear_flags();
    tick();
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.ivalid", {31'd0, instr_valid}, 32'd0);
    chk("rst.count", instr_count, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    chk("rst.opcode", {26'd0, opcode}, 32'd0);
    rst_n = 1'b1;

    // add at pc 0
    tick();
    chk("add.req", {31'd0, imem_req}, 32'd1);
    chk("add.addr", imem_addr, 32'h0);
    tick();
    chk("add.ivalid", {31'd0, instr_valid}, 32'd1);
    chk("add.req_off", {31'd0, imem_req}, 32'd0);
    chk("add.opcode", {26'd0, opcode}, 32'h00);
    chk("add.funct", {26'd0, funct}, 32'h20);
    chk("add.rs", {27'd0, rs_addr}, 32'd9);
    chk("add.rt", {27'd0, rt_addr}, 32'd10);
    chk("add.rd", {27'd0, rd_addr}, 32'd8);
    chk("add.shamt", {27'd0, shamt}, 32'd0);
    imem_valid = 1'b0;
    retire();
    chk("add.pc", pc_out, 32'h4);
    chk("add.count", instr_count, 32'd1);
    chk("add.next_addr", imem_addr, 32'h4);
    chk("add.next_req", {31'd0, imem_req}, 32'd1);

    // pc_write outside DECODE has no effect
    pc_write = 1'b1;
    tick();
    pc_write = 1'b0;
    chk("stray_pcw.pc", pc_out, 32'h4);
    chk("stray_pcw.count", instr_count, 32'd1);

    // j 0x10, then beq taken
    fetch("j1", 32'h0800_0004);
    jump = 1'b1; retire();
    chk("j1.pc", pc_out, 32'h10);
    fetch("beq1", 32'h1109_0003);
    chk("beq1.imm", {16'd0, imm}, 32'h0003);
    chk("beq1.pcp4", pcp4, 32'h14);
    beq = 1'b1; zero = 1'b1; retire();
    chk("beq_taken.pc", pc_out, 32'h20);

    // back to 0x10, beq not taken
    fetch("j2", 32'h0800_0004);
    jump = 1'b1; retire();
    chk("j2.pc", pc_out, 32'h10);
    fetch("beq2", 32'h1109_0003);
    beq = 1'b1; zero = 1'b0; retire();
    chk("beq_nt.pc", pc_out, 32'h14);
    chk("beq_nt.count", instr_count, 32'd5);

    // jr wins over jump
    fetch("jr1", 32'h0800_0004);
    jr = 1'b1; jump = 1'b1; rs_data = 32'h1000_0008; retire();
    chk("jr_prio.pc", pc_out, 32'h1000_0008);
    chk("jr_prio.fault", {31'd0, fault}, 32'd0);

    fetch("jal", 32'h0C00_0040);
    chk("jal.pcp4", pcp4, 32'h1000_000C);
    jal = 1'b1; retire();
    chk("jal.pc", pc_out, 32'h1000_0100);

    fetch("bne", 32'h1509_FFFE);
    bne = 1'b1; retire();
    chk("bne_back.pc", pc_out, 32'h1000_00FC);
    fetch("bgt", 32'h1D09_0004);
    bgt = 1'b1; zero = 1'b1; retire();
    chk("bgt_nt.pc", pc_out, 32'h1000_0100);
    fetch("ble", 32'h1909_0004);
    ble = 1'b1; zero = 1'b1; retire();
    chk("ble_eq.pc", pc_out, 32'h1000_0114);
    fetch("bge", 32'h0509_0002);
    bge = 1'b1; lt = 1'b1; retire();
    chk("bge_nt.pc", pc_out, 32'h1000_0118);
    fetch("blt", 32'h0509_0002);
    blt = 1'b1; lt = 1'b1; retire();
    chk("blt_t.pc", pc_out, 32'h1000_0124);
    chk("blt_t.count", instr_count, 32'd12);

    // Run dropped during DECODE: instruction still completes, then IDLE
    fetch("stop", 32'h012A_4020);
    run = 1'b0;
    tick();
    chk("stop.wait_ivalid", {31'd0, instr_valid}, 32'd1);
    chk("stop.wait_pc", pc_out, 32'h1000_0124);
    retire();
    chk("stop.pc", pc_out, 32'h1000_0128);
    chk("stop.req", {31'd0, imem_req}, 32'd0);
    chk("stop.ivalid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("stop.idle_req", {31'd0, imem_req}, 32'd0);
    run = 1'b1;
    tick();
    chk("restart.req", {31'd0, imem_req}, 32'd1);
    chk("restart.addr", imem_addr, 32'h1000_0128);

    // pcp4 wrap
    fetch("jr_top", 32'h03E0_0008);
    jr = 1'b1; rs_data = 32'hFFFF_FFFC; retire();
    chk("wrap.pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap.pcp4", pcp4, 32'h0);
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);

    // misaligned jr
    fetch("jr_bad", 32'h03E0_0008);
    jr = 1'b1; rs_data = 32'h0000_0203; retire();
    chk("jr_bad.pc", pc_out, 32'h200);
    chk("jr_bad.fault", {31'd0, fault}, 32'd1);
    chk("jr_bad.req", {31'd0, imem_req}, 32'd0);
    chk("jr_bad.count", instr_count, 32'd15);
    repeat (3) tick();
    chk("jr_bad.stuck_req", {31'd0, imem_req}, 32'd0);
    chk("jr_bad.stuck_fault", {31'd0, fault}, 32'd1);

    // fetch timeout
    do_reset();
    chk("rst2.fault", {31'd0, fault}, 32'd0);
    chk("rst2.pc", pc_out, 32'h0);
    tick();
    chk("to.req", {31'd0, imem_req}, 32'd1);
    repeat (15) tick();
    chk("to.15_fault", {31'd0, fault}, 32'd0);
    chk("to.15_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("to.16_fault", {31'd0, fault}, 32'd1);
    chk("to.16_req", {31'd0, imem_req}, 32'd0);

    // async reset mid-DECODE
    do_reset();
    tick();
    fetch("ar1", 32'h012A_4020);
    retire();
    fetch("ar2", 32'h012A_4020);
    chk("ar.pre_pc", pc_out, 32'h4);
    chk("ar.pre_count", instr_count, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.pc", pc_out, 32'h0);
    chk("ar.ivalid", {31'd0, instr_valid}, 32'd0);
    chk("ar.count", instr_count, 32'd0);
    chk("ar.funct", {26'd0, funct}, 32'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1);
  end

endmodule
